fpga_reset_sequencer: RTL and testbench



---
 rtl/fpga_rstseq_pkg.sv | 30 +++
 rtl/rstseq_debounce.sv | 61 ++++++
 rtl/fpga_reset_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fpga_reset_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_rstseq_pkg.sv
// Shared types and elaboration-time helpers for the FPGA reset sequencer.
package fpga_rstseq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SD_OFF    = 3'd1,
    SD_ON     = 3'd2,
    SOC_HOLD  = 3'd3,
    RUN       = 3'd4
  } rstseq_state_e;

  // A zero-length phase still occupies one cycle.
  function automatic int eff_cycles(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int cnt_width(input int max_cycles);
    return $clog2(max_cycles) + 1;
  endfunction

endpackage

// File: rtl/rstseq_debounce.sv
// Synchroniser plus stability filter for an asynchronous level; output is either
// the filtered level or a one-cycle pulse on its 1->0 transition.
module rstseq_debounce
  import fpga_rstseq_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1,
  parameter logic RESET_LEVEL     = 1'b1,
  parameter bit   PULSE_OUT       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic out_o
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int DB_N   = eff_cycles(DEBOUNCE_CYCLES);
  localparam int DW     = cnt_width(DB_N);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_N - 1);

  logic [STAGES-1:0] sync;
  logic [DW-1:0]     stable_cnt;
  logic              synced;
  logic              level;
  logic              fall;

  assign synced = sync[STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync <= {STAGES{RESET_LEVEL}};
    end else begin
      sync <= {sync[STAGES-2:0], raw_i};
    end
  end

  // Level follows the synchronised input only after DB_N consecutive differing cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level      <= RESET_LEVEL;
      stable_cnt <= '0;
      fall       <= 1'b0;
    end else if (synced != level) begin
      if (stable_cnt == DB_LAST) begin
        level      <= synced;
        stable_cnt <= '0;
        fall       <= level & ~synced;
      end else begin
        stable_cnt <= stable_cnt + DW'(1);
        fall       <= 1'b0;
      end
    end else begin
      stable_cnt <= '0;
      fall       <= 1'b0;
    end
  end

  assign out_o = PULSE_OUT ? fall : level;

endmodule

// File: rtl/fpga_reset_sequencer.sv
// Board power-up sequencer: PLL lock -> SD power cycle -> SoC reset hold -> RUN.
// Optional macro FPGA_RSTSEQ_SW_REQ_EN adds a software SoC-only reset request.
module fpga_reset_sequencer
  import fpga_rstseq_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int LOCK_CYCLES      = 1024,
  parameter int SD_OFF_CYCLES    = 2000000,
  parameter int SD_SETTLE_CYCLES = 1000000,
  parameter int SOC_RST_CYCLES   = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       btn_rst_ni,
`ifdef FPGA_RSTSEQ_SW_REQ_EN
  input  logic       sw_rst_req_i,
`endif
  output logic       soc_rst_no,
  output logic       sd_pwr_no,
  output logic       busy_o,
  output logic [2:0] state_o,
  output logic       btn_press_o
);

  localparam int LOCK_N   = eff_cycles(LOCK_CYCLES);
  localparam int OFF_N    = eff_cycles(SD_OFF_CYCLES);
  localparam int SETTLE_N = eff_cycles(SD_SETTLE_CYCLES);
  localparam int HOLD_N   = eff_cycles(SOC_RST_CYCLES);
  localparam int CW       = cnt_width(max_of4(LOCK_N, OFF_N, SETTLE_N, HOLD_N));

  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_N - 1);
  localparam logic [CW-1:0] OFF_LAST    = CW'(OFF_N - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_N - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_N - 1);

  rstseq_state_e state;
  rstseq_state_e nxt;
  logic [CW-1:0] phase_cnt;
  logic          lock_ok;
  logic          press;

  rstseq_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (1),
    .RESET_LEVEL     (1'b0),
    .PULSE_OUT       (1'b0)
  ) u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .raw_i (pll_locked_i),
    .out_o (lock_ok)
  );

  rstseq_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b1),
    .PULSE_OUT       (1'b1)
  ) u_btn_debounce (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .raw_i (btn_rst_ni),
    .out_o (press)
  );

  assign btn_press_o = press;
  assign state_o     = state;

`ifdef FPGA_RSTSEQ_SW_REQ_EN
  logic sw_armed;
  logic sw_take;
`endif

  // Next-state selection: lock loss beats button, button beats software request and timers.
  always_comb begin
    nxt = state;
`ifdef FPGA_RSTSEQ_SW_REQ_EN
    sw_take = 1'b0;
`endif
    if (state != WAIT_LOCK && !lock_ok) begin
      nxt = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lock_ok && phase_cnt == LOCK_LAST) nxt = SD_OFF;
          else                                    nxt = WAIT_LOCK;
        end
        SD_OFF: begin
          if (phase_cnt == OFF_LAST) nxt = SD_ON;
          else                       nxt = SD_OFF;
        end
        SD_ON: begin
          if (phase_cnt == SETTLE_LAST) nxt = SOC_HOLD;
          else                          nxt = SD_ON;
        end
        SOC_HOLD: begin
          if (phase_cnt == HOLD_LAST) nxt = RUN;
          else                        nxt = SOC_HOLD;
        end
        RUN: begin
          if (press) begin
            nxt = SD_OFF;
`ifdef FPGA_RSTSEQ_SW_REQ_EN
          end else if (sw_rst_req_i && sw_armed) begin
            nxt     = SOC_HOLD;
            sw_take = 1'b1;
`endif
          end else begin
            nxt = RUN;
          end
        end
        default: nxt = WAIT_LOCK;
      endcase
    end
  end

  // State register with outputs decoded from the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= WAIT_LOCK;
      soc_rst_no <= 1'b0;
      sd_pwr_no  <= 1'b1;
      busy_o     <= 1'b1;
    end else begin
      state      <= nxt;
      soc_rst_no <= (nxt == RUN);
      sd_pwr_no  <= (nxt == WAIT_LOCK) || (nxt == SD_OFF);
      busy_o     <= (nxt != RUN);
    end
  end

  // Phase counter restarts on every state entry; in WAIT_LOCK it counts consecutive lock-high cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_cnt <= '0;
    end else if (nxt != state || state == RUN) begin
      phase_cnt <= '0;
    end else if (state == WAIT_LOCK && !lock_ok) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + CW'(1);
    end
  end

`ifdef FPGA_RSTSEQ_SW_REQ_EN
  // A held request is consumed once; it must drop for a cycle before it can fire again.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_armed <= 1'b1;
    end else if (sw_take) begin
      sw_armed <= 1'b0;
    end else if (!sw_rst_req_i) begin
      sw_armed <= 1'b1;
    end else begin
      sw_armed <= sw_armed;
    end
  end
`endif

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Randomised scoreboard bench for fpga_reset_sequencer against a cycle-level reference model.
module tb_fpga_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int DB     = 4;
  localparam int LOCK   = 4;
  localparam int SDOFF  = 6;
  localparam int SDSET  = 5;
  localparam int SOCR   = 3;

  localparam int S_WAIT = 0;
  localparam int S_OFF  = 1;
  localparam int S_ON   = 2;
  localparam int S_HOLD = 3;
  localparam int S_RUN  = 4;

`ifdef FPGA_RSTSEQ_SW_REQ_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, lock, btn, sw;
  logic       soc_rst_no, sd_pwr_no, busy_o, btn_press_o;
  logic [2:0] state_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int dut_presses = 0;

  logic [6:0] exp_q[$];

  fpga_reset_sequencer #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DB),
    .LOCK_CYCLES      (LOCK),
    .SD_OFF_CYCLES    (SDOFF),
    .SD_SETTLE_CYCLES (SDSET),
    .SOC_RST_CYCLES   (SOCR)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pll_locked_i (lock),
    .btn_rst_ni   (btn),
`ifdef FPGA_RSTSEQ_SW_REQ_EN
    .sw_rst_req_i (sw),
`endif
    .soc_rst_no   (soc_rst_no),
    .sd_pwr_no    (sd_pwr_no),
    .busy_o       (busy_o),
    .state_o      (state_o),
    .btn_press_o  (btn_press_o)
  );

  always #5 clk = ~clk;

  // Reference model: delayed input histories, run-length filters and phase timers.
  bit lk_hist[SYNC];
  bit bt_hist[SYNC];
  bit lk_lvl, bt_lvl, m_press, m_armed;
  int bt_run, m_st, m_ph;

  function automatic int phase_len(input int st);
    case (st)
      S_OFF:   return SDOFF;
      S_ON:    return SDSET;
      S_HOLD:  return SOCR;
      default: return 1;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit l, input bit b, input bit s);
    bit lk_seen, bt_seen, lk_prev, pr_prev;
    int nst;
    if (r) begin
      for (int i = 0; i < SYNC; i++) begin
        lk_hist[i] = 1'b0;
        bt_hist[i] = 1'b1;
      end
      lk_lvl = 1'b0; bt_lvl = 1'b1; m_press = 1'b0; m_armed = 1'b1;
      bt_run = 0; m_st = S_WAIT; m_ph = 0;
      return;
    end
    lk_seen = lk_hist[SYNC-1];
    bt_seen = bt_hist[SYNC-1];
    lk_prev = lk_lvl;
    pr_prev = m_press;
    for (int i = SYNC - 1; i > 0; i--) begin
      lk_hist[i] = lk_hist[i-1];
      bt_hist[i] = bt_hist[i-1];
    end
    lk_hist[0] = l;
    bt_hist[0] = b;
    lk_lvl  = lk_seen;
    m_press = 1'b0;
    if (bt_seen != bt_lvl) begin
      bt_run++;
      if (bt_run >= DB) begin
        m_press = bt_lvl && !bt_seen;
        bt_lvl  = bt_seen;
        bt_run  = 0;
      end
    end else begin
      bt_run = 0;
    end
    nst = m_st;
    if (m_st != S_WAIT && !lk_prev) nst = S_WAIT;
    else if (m_st == S_WAIT) begin
      if (lk_prev && m_ph + 1 >= LOCK) nst = S_OFF;
    end else if (m_st == S_RUN) begin
      if (pr_prev) nst = S_OFF;
      else if (SW_EN && s && m_armed) nst = S_HOLD;
    end else if (m_ph + 1 >= phase_len(m_st)) begin
      nst = m_st + 1;
    end
    if (SW_EN) begin
      if (m_st == S_RUN && lk_prev && !pr_prev && s && m_armed) m_armed = 1'b0;
      else if (!s) m_armed = 1'b1;
    end
    if (nst != m_st || nst == S_RUN || (m_st == S_WAIT && !lk_prev)) m_ph = 0;
    else m_ph++;
    m_st = nst;
  endtask

  task automatic tick();
    logic [2:0] st3;
    @(posedge clk);
    cyc++;
    model_step(rst, lock, btn, sw);
    st3 = m_st[2:0];
    exp_q.push_back({st3, m_st == S_RUN, m_st < S_ON, m_st != S_RUN, m_press});
    #1;
  endtask

  task automatic wait_state(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (m_st != target && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (state_o != 3'(target)) begin
      n_fail++;
      $display("FAIL wait_%s: state_o=%0d after %0d cycles, required %0d", tag, state_o, k, target);
    end
  endtask

  // Monitor: every cycle the DUT presents a new output set, pop and compare.
  initial begin
    logic [6:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state_o, soc_rst_no, sd_pwr_no, busy_o, btn_press_o};
        if (btn_press_o === 1'b1) dut_presses++;
        n_cmp++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d: got st=%0d soc=%b sd=%b busy=%b press=%b, required st=%0d soc=%b sd=%b busy=%b press=%b",
                   cyc, a[6:4], a[3], a[2], a[1], a[0], e[6:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst = 1'b1; lock = 1'b1; btn = 1'b1; sw = 1'b0;

    // Power-up with lock already present.
    repeat (3) tick();
    rst = 1'b0;
    wait_state(S_RUN, 60, "powerup");
    repeat (3) tick();

    // Lock glitch while counting in WAIT_LOCK.
    rst = 1'b1; lock = 1'b0;
    repeat (3) tick();
    rst = 1'b0; lock = 1'b1;
    repeat (3) tick();
    lock = 1'b0;
    tick();
    lock = 1'b1;
    wait_state(S_OFF, 20, "glitch");
    wait_state(S_RUN, 40, "glitch_run");

    // Bouncing button in RUN: exactly one accepted press.
    p0 = dut_presses;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      repeat (2) tick();
    end
    btn = 1'b0;
    repeat (12) tick();
    btn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dut_presses - p0 != 1) begin
      n_fail++;
      $display("FAIL bounce_presses: got %0d, required 1", dut_presses - p0);
    end

    // Lock lost during SD_ON.
    wait_state(S_ON, 40, "sd_on");
    repeat (2) tick();
    lock = 1'b0;
    repeat (6) tick();
    lock = 1'b1;
    wait_state(S_RUN, 60, "lockloss_run");

    // Synchronous reset while in SOC_HOLD.
    btn = 1'b0;
    repeat (8) tick();
    btn = 1'b1;
    wait_state(S_HOLD, 40, "hold");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_state(S_RUN, 60, "reset_run");

    if (SW_EN) begin
      sw = 1'b1;
      tick();
      sw = 1'b0;
      repeat (2) tick();
      wait_state(S_RUN, 20, "sw_pulse");
      sw = 1'b1;
      repeat (10) tick();
      sw = 1'b0;
      repeat (3) tick();
      btn = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        sw = m_press;
      end
      btn = 1'b1; sw = 1'b0;
      wait_state(S_RUN, 60, "sw_btn");
    end

    // Randomised traffic on all inputs.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 39) == 0) lock = ~lock;
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      sw = ($urandom_range(0, 19) == 0);
      tick();
    end
    rst = 1'b0; lock = 1'b1; btn = 1'b1; sw = 1'b0;
    wait_state(S_RUN, 80, "final_run");

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
